dual_debounce: RTL

- Cleans two raw asynchronous board inputs (push-buttons or slide switches) into glitch-free, clock-synchronous levels a and b.
- The outputs feed the 2-input OR gate stage directly.
- Also provides one-cycle rise and fall pulses per channel for downstream counters and LED demos.
- Each channel is independent: a 2-flop synchronizer followed by a stability counter.

---
 rtl/dual_debounce_pkg.sv | 13 +
 rtl/dual_debounce_ch.sv | 61 ++++++
 rtl/dual_debounce.sv | 44 ++++
 3 files changed

// File: rtl/dual_debounce_pkg.sv
// Shared constants for the board-input debouncers.
package dual_debounce_pkg;

  localparam int unsigned DEBOUNCE_10MS_100MHZ = 1000000;
  localparam int unsigned DEBOUNCE_CNT_W       = 20;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10
  } edge_kind_e;

endpackage : dual_debounce_pkg

// File: rtl/dual_debounce_ch.sv
// Single-channel debouncer: 2-flop synchronizer, stability counter and
// registered rise/fall pulses coincident with the clean-level change.
module debounce_ch
  import dual_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DEBOUNCE_10MS_100MHZ,
  parameter int unsigned CNT_W      = DEBOUNCE_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  edge_kind_e       edge_q, edge_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    edge_d  = EDGE_NONE;
    // Any sample agreeing with the clean level restarts the count.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = sync2_q;
      edge_d  = sync2_q ? EDGE_RISE : EDGE_FALL;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      edge_q  <= EDGE_NONE;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      edge_q  <= edge_d;
    end
  end

  assign level = level_q;
  assign rise  = (edge_q == EDGE_RISE);
  assign fall  = (edge_q == EDGE_FALL);

endmodule : debounce_ch

// File: rtl/dual_debounce.sv
// Two independent debounced board inputs feeding the OR-gate stage.
module dual_debounce
  import dual_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DEBOUNCE_10MS_100MHZ,
  parameter int unsigned CNT_W      = DEBOUNCE_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_a,
  input  logic btn_b,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  debounce_ch #(
    .STABLE_CNT(STABLE_CNT),
    .CNT_W     (CNT_W)
  ) u_ch_a (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_a),
    .level(a),
    .rise (a_rise),
    .fall (a_fall)
  );

  debounce_ch #(
    .STABLE_CNT(STABLE_CNT),
    .CNT_W     (CNT_W)
  ) u_ch_b (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_b),
    .level(b),
    .rise (b_rise),
    .fall (b_fall)
  );

endmodule : dual_debounce
